pixel_write_buffer: RTL and testbench

Downstream stage of ComputationalCore. Accepts rasterised pixels (address, color, frame_target) over the data_ready/data_sent handshake and stores them in a small FIFO. Drains the FIFO to the frame-buffer SRAM controller through a hold-until-ack write port. Reports when a completed shape's pixels are fully committed to memory, so the core's throughput is decoupled from SRAM latency.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/pixel_fifo.sv | 53 +++++
 rtl/pixel_write_buffer.sv | 106 ++++++++++
 tb/tb_pixel_write_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared frame geometry, pixel record and drain state types
package gpu_pkg;

  localparam int FRAME_W     = 640;
  localparam int FRAME_H     = 480;
  localparam int MAX_PIXELS  = FRAME_W * FRAME_H;
  localparam int PIX_ADDR_W  = 19;
  localparam int PIX_COLOR_W = 16;

  typedef struct packed {
    logic                   frame_target;
    logic [PIX_ADDR_W-1:0]  address;
    logic [PIX_COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO of pixel_t with modulo pointers and occupancy count
module pixel_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic                   pop,
  input  pixel_t                 push_data,
  output pixel_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  pixel_t           store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = store[rd_ptr];

  // Storage is left unreset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// rtl/pixel_write_buffer.sv - buffers rasterised pixels and drains them to SRAM with flush reporting
module pixel_write_buffer
  import gpu_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = PIX_ADDR_W,
  parameter int COLOR_W    = PIX_COLOR_W,
  parameter int MAX_PIXELS = gpu_pkg::MAX_PIXELS
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               data_ready,
  input  logic [ADDR_W-1:0]  address,
  input  logic [COLOR_W-1:0] color,
  input  logic               frame_target,
  input  logic               shape_done,
  output logic               data_sent,
  output logic [ADDR_W:0]    mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_we,
  input  logic               mem_ack,
  output logic               flush_done,
  output logic [7:0]         drop_count,
  output logic               full
);

  drain_state_t           state;
  drain_state_t           state_next;
  pixel_t                 head;
  pixel_t                 incoming;
  logic                   in_range;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   load;
  logic                   empty;
  logic                   pending;
  logic [$clog2(DEPTH):0] fifo_count;

  assign in_range = (address < ADDR_W'(MAX_PIXELS));
  // Out-of-range pixels are acknowledged even when full so a bad pixel never stalls the core.
  assign accept   = data_ready && !data_sent && (!full || !in_range);
  assign push     = accept && in_range;
  assign incoming = '{frame_target: frame_target, address: address, color: color};

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .pop       (pop),
    .push_data (incoming),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load       = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_we     = (state == WRITE);
  assign flush_done = pending && (fifo_count == '0) && (state == IDLE) && !accept;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_sent  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      drop_count <= '0;
      pending    <= 1'b0;
    end else begin
      data_sent <= accept;
      if (load) begin
        mem_addr  <= {head.frame_target, head.address};
        mem_wdata <= head.color;
      end
      if (accept && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (shape_done)      pending <= 1'b1;
      else if (flush_done) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb/tb_pixel_write_buffer.sv - scoreboard bench for pixel_write_buffer
module tb_pixel_write_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        data_ready;
  logic [18:0] address;
  logic [15:0] color;
  logic        frame_target;
  logic        shape_done;
  logic        data_sent;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        flush_done;
  logic [7:0]  drop_count;
  logic        full;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_lat = 0;
  bit ack_en = 1'b1;
  int wait_cnt = 0;
  int write_total = 0;
  int flush_total = 0;
  int flush_cyc = 0;
  int last_ack_cyc = 0;
  logic [35:0] sb[$];
  logic        prev_we = 1'b0;
  logic [19:0] prev_addr;
  logic [15:0] prev_wdata;

  pixel_write_buffer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .data_ready   (data_ready),
    .address      (address),
    .color        (color),
    .frame_target (frame_target),
    .shape_done   (shape_done),
    .data_sent    (data_sent),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .flush_done   (flush_done),
    .drop_count   (drop_count),
    .full         (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: acknowledges after mem_we has been seen for ack_lat cycles
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_we && ack_en) begin
        if (wait_cnt >= ack_lat) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!n_rst) prev_we = 1'b0;
    else begin
      if (mem_we && prev_we) begin
        vectors++;
        if (mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
          miscompares++;
          $display("FAIL hold_stable: addr=%h data=%h, required addr=%h data=%h", mem_addr, mem_wdata, prev_addr, prev_wdata);
        end
      end
      if (flush_done) begin
        flush_total++;
        flush_cyc = cyc;
      end
      if (mem_we && mem_ack) begin
        logic [35:0] exp;
        write_total++;
        last_ack_cyc = cyc;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
        end else begin
          exp = sb.pop_front();
          if ({mem_addr, mem_wdata} !== exp) begin
            miscompares++;
            $display("FAIL write_data: got %h, required %h", {mem_addr, mem_wdata}, exp);
          end
        end
      end
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  task automatic send_pixel(input logic [18:0] a, input logic [15:0] c, input logic ft);
    bit got = 1'b0;
    data_ready = 1'b1; address = a; color = c; frame_target = ft;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (data_sent) begin
        got = 1'b1;
        break;
      end
    end
    data_ready = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL send_timeout: addr=%0d not acknowledged, required data_sent", a);
    end else if (a < 19'd307200) sb.push_back({ft, a, c});
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mem_we) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", sb.size());
    end
  endtask

  task automatic pulse_shape_done(output int at_cyc);
    @(posedge clk);
    #1;
    shape_done = 1'b1;
    at_cyc = cyc;
    @(posedge clk);
    #1;
    shape_done = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; data_ready = 1'b0; address = '0; color = '0; frame_target = 1'b0; shape_done = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({data_sent, mem_we, flush_done, full, drop_count, mem_addr, mem_wdata} !== 48'd0) begin
      miscompares++;
      $display("FAIL reset_state: sent=%b we=%b fd=%b full=%b drops=%0d addr=%h data=%h, required all 0",
               data_sent, mem_we, flush_done, full, drop_count, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #2;
    n_rst = 1'b1;
  endtask

  task automatic test_single_pixel();
    bit seen = 1'b0;
    ack_lat = 2;
    send_pixel(19'd100, 16'hF800, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if (data_sent !== 1'b0) begin
      miscompares++;
      $display("FAIL data_sent_pulse: data_sent=%b, required 0 on second cycle", data_sent);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen || mem_addr !== 20'h80064 || mem_wdata !== 16'hF800) begin
      miscompares++;
      $display("FAIL single_write: we=%b addr=%h data=%h, required we=1 addr=80064 data=f800", seen, mem_addr, mem_wdata);
    end
    wait_drain();
  endtask

  task automatic test_out_of_range();
    int base = write_total;
    ack_lat = 0;
    send_pixel(19'd307200, 16'h1234, 1'b0);
    vectors++;
    if (drop_count !== 8'd1) begin
      miscompares++;
      $display("FAIL drop_count_one: drop_count=%0d, required 1", drop_count);
    end
    send_pixel(19'd307199, 16'h07E0, 1'b0);
    wait_drain();
    vectors++;
    if (write_total !== base + 1) begin
      miscompares++;
      $display("FAIL oor_write_count: %0d writes, required %0d", write_total - base, 1);
    end
  endtask

  task automatic test_backpressure();
    int  base = write_total;
    bit  got = 1'b0;
    int  stall_sent = 0;
    ack_en = 1'b0;
    ack_lat = 1;
    for (int i = 0; i < 8; i++) send_pixel(19'(1000 + i), 16'(16'hA000 + i), i[0]);
    vectors++;
    if (full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_after_8: full=%b, required 1", full);
    end
    data_ready = 1'b1; address = 19'd2000; color = 16'hBEEF; frame_target = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (data_sent) stall_sent++;
    end
    vectors++;
    if (stall_sent != 0) begin
      miscompares++;
      $display("FAIL stall_when_full: data_sent seen %0d times, required 0", stall_sent);
    end
    ack_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (data_sent) begin
        got = 1'b1;
        break;
      end
    end
    data_ready = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ninth_accept: data_sent=0, required 1 after drain starts");
    end else sb.push_back({1'b1, 19'd2000, 16'hBEEF});
    wait_drain();
    vectors++;
    if (write_total !== base + 9) begin
      miscompares++;
      $display("FAIL backpressure_count: %0d writes, required 9", write_total - base);
    end
  endtask

  task automatic test_flush();
    int base;
    int sd_cyc;
    ack_lat = 3;
    base = flush_total;
    send_pixel(19'd10, 16'h0001, 1'b0);
    send_pixel(19'd11, 16'h0002, 1'b0);
    pulse_shape_done(sd_cyc);
    send_pixel(19'd12, 16'h0003, 1'b1);
    pulse_shape_done(sd_cyc);
    wait_drain();
    repeat (5) @(negedge clk);
    vectors++;
    if (flush_total - base !== 1 || flush_cyc !== last_ack_cyc + 1) begin
      miscompares++;
      $display("FAIL flush_after_shape: pulses=%0d at cycle %0d, required 1 at cycle %0d",
               flush_total - base, flush_cyc, last_ack_cyc + 1);
    end
    base = flush_total;
    pulse_shape_done(sd_cyc);
    repeat (4) @(negedge clk);
    vectors++;
    if (flush_total - base !== 1 || flush_cyc !== sd_cyc + 1) begin
      miscompares++;
      $display("FAIL flush_empty: pulses=%0d at cycle %0d, required 1 at cycle %0d",
               flush_total - base, flush_cyc, sd_cyc + 1);
    end
  endtask

  task automatic test_reset_mid_write();
    int base;
    ack_en = 1'b0;
    for (int i = 0; i < 8; i++) send_pixel(19'(500 + i), 16'(16'h5500 + i), 1'b0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_state: we=%b full=%b, required 1 1", mem_we, full);
    end
    #2;
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({mem_we, data_sent, full, drop_count} !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset: we=%b sent=%b full=%b drops=%0d, required all 0", mem_we, data_sent, full, drop_count);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b1;
    ack_en = 1'b1;
    base = write_total;
    repeat (10) @(negedge clk);
    vectors++;
    if (write_total !== base || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL no_write_after_reset: writes=%0d we=%b, required 0 0", write_total - base, mem_we);
    end
  endtask

  task automatic test_saturation();
    int base = write_total;
    for (int i = 0; i < 300; i++) send_pixel(19'(307200 + i), 16'hFFFF, i[0]);
    repeat (5) @(negedge clk);
    vectors++;
    if (drop_count !== 8'd255 || write_total !== base) begin
      miscompares++;
      $display("FAIL drop_saturation: drop_count=%0d writes=%0d, required 255 0", drop_count, write_total - base);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_out_of_range();
    test_backpressure();
    test_flush();
    test_reset_mid_write();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
